chunked_seq_adder: RTL
======================

Name: chunked_seq_adder

Overview:
- Multi-cycle, parametrised successor to the combinational ripple adder.
- Adds two WIDTH-bit operands one CHUNK-bit slice per clock, carrying between slices in a register. Short combinational carry chain, so it reaches high clock rates on wide datapaths.
- Supports add/subtract mode, external carry-in, carry-out and signed overflow.
- Valid/ready handshake on both sides; sits between operand producers and the carry-save/accumulate datapath.

Parameters:
- WIDTH, 64, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 16, bits added per cycle; 1 <= CHUNK <= WIDTH. NUM_CHUNKS = WIDTH/CHUNK (derived, not overridable).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  operands/mode valid
- o_ready  output  1  block can accept an operation
- i_add1  input  WIDTH  operand A
- i_add2  input  WIDTH  operand B
- i_cin  input  1  carry-in, used only when i_sub=0
- i_sub  input  1  1: A-B, 0: A+B+i_cin
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_result  output  WIDTH  sum/difference (mod 2^WIDTH)
- o_cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- o_ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (i_rst=1 at a rising edge): state IDLE, o_ready=1, o_valid=0, o_result=0, o_cout=0, o_ovf=0, chunk index=0, carry register=0. Reset overrides all other inputs. Reset mid-operation aborts and discards the operation; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1, capture A and B' = i_sub ? ~i_add2 : i_add2, and carry = i_sub ? 1 : i_cin.
  - Index=0, go to RUN. o_result is cleared on acceptance.
- RUN:
  - o_ready=0.
  - Each cycle: slice j = bits [j*CHUNK +: CHUNK]; sum = A_j + B'_j + carry (CHUNK+1 bits).
  - Write the low CHUNK bits into result slice j; carry <= bit CHUNK; index++.
  - On the last slice (j = NUM_CHUNKS-1): set o_cout = final carry and o_ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). Go to DONE.
- DONE:
  - o_valid=1, o_ready=0.
  - o_result/o_cout/o_ovf held stable while i_ready=0.
  - On i_ready=1, go to IDLE; o_valid drops the next cycle. Outputs keep their last value until the next acceptance.
- Latency: acceptance edge E0; slice j written at edge E(j+1); o_valid high from edge E(NUM_CHUNKS). For 64/16 this is 4 cycles after acceptance.
- Throughput: one operation per NUM_CHUNKS+2 cycles at most; no overlap.
- i_valid is ignored whenever o_ready=0. Input values are only sampled at the acceptance edge; later input changes have no effect.
- NUM_CHUNKS=1: RUN lasts exactly one cycle (fully combinational add, registered).
- The index counter is sized clog2(NUM_CHUNKS) with a minimum of 1 bit and never exceeds NUM_CHUNKS-1.
- Simultaneous i_valid and i_ready in DONE: the result handshake completes, the new operand is not accepted (o_ready=0), and it must be re-presented in IDLE.

Test Plan (WIDTH=64, CHUNK=16 unless noted):
- Wrap-around: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0, sub=0 -> result 0, cout=1, ovf=0, o_valid exactly 4 cycles after the acceptance edge.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result 0x8000_0000_0000_0000, cout=0, ovf=1. Inter-slice carry: A=0x0000_0000_0000_FFFF, B=1, cin=1 -> 0x0000_0000_0001_0001.
- Subtract: 5-7 -> 0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also 0x8000_0000_0000_0000 - 1 -> 0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1. Confirm i_cin=1 is ignored when sub=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while toggling i_valid and operands -> outputs stable, o_ready=0, nothing accepted. Then i_ready=1 -> o_valid=0 and o_ready=1 the next cycle.
- Reset mid-op: assert i_rst at the edge that would write slice 2 -> the next cycle shows o_valid=0, o_ready=1, o_result=0, o_cout=0, o_ovf=0. A following operation 3+4 yields 7.
- Parameter sweep: (64,64), (64,8), (32,1). Run 1000 random add/sub operations with random back-pressure -> all outputs match a reference model, latency = NUM_CHUNKS cycles.

Source files
------------

// File: rtl/chunked_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_seq_adder
// Brief    : Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock,
//            with registered inter-slice carry and valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_seq_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_ready;
    logic             r_valid;

    logic [CHUNK-1:0] w_a_chunks [NUM_CHUNKS];
    logic [CHUNK-1:0] w_b_chunks [NUM_CHUNKS];
    logic [CHUNK-1:0] w_a_j;
    logic [CHUNK-1:0] w_b_j;
    logic [CHUNK:0]   w_sum;
    logic             w_msb_cin;

    for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_slice
        assign w_a_chunks[g] = r_a[g*CHUNK +: CHUNK];
        assign w_b_chunks[g] = r_b[g*CHUNK +: CHUNK];
    end

    assign w_a_j = w_a_chunks[r_idx];
    assign w_b_j = w_b_chunks[r_idx];
    assign w_sum = {1'b0, w_a_j} + {1'b0, w_b_j} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the top bit of the slice, recovered from the sum bit itself
    assign w_msb_cin = w_a_j[CHUNK-1] ^ w_b_j[CHUNK-1] ^ w_sum[CHUNK-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a      <= i_add1;
                        r_b      <= i_sub ? ~i_add2 : i_add2;
                        r_carry  <= i_sub ? 1'b1 : i_cin;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < NUM_CHUNKS; j++) begin
                        if (r_idx == IDX_W'(j)) begin
                            r_result[j*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                        end
                    end
                    r_carry <= w_sum[CHUNK];
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_sum[CHUNK];
                        r_ovf   <= w_msb_cin ^ w_sum[CHUNK];
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // A new operand offered alongside i_ready is not taken here
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_ovf    = r_ovf;

endmodule
`default_nettype wire
